iiitb_rc_chk: RTL and testbench
===============================

IIITB_RC_CHK -- requirements
Module: iiitb_rc_chk

Interface
REQ-001 SHALL provide parameter LOCK_CNT, default 4: consecutive legal, correctly rotated samples needed to declare lock (range 2..15).
REQ-002 SHALL provide parameter DIR, default 0: 0 = expected rotation left (next = {cur[2:0],cur[3]}); 1 = rotation right (next = {cur[0],cur[3:1]}).
REQ-003 SHALL provide parameter CNT_W, default 8: width of err_cnt.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  sample enable; rc_in is evaluated only on edges where en=1.
REQ-007 clr_err  input  1  synchronous clear of err_cnt.
REQ-008 rc_in  input  4  one-hot ring-counter pattern under check.
REQ-009 idx  output  2  binary position of the set bit of the last legal sample.
REQ-010 valid  output  1  high while locked and the last sample was the correct rotation.
REQ-011 locked  output  1  high in state LOCKED.
REQ-012 err  output  1  one-cycle pulse on a rotation/legality fault detected while LOCKED.
REQ-013 wrap  output  1  one-cycle pulse when a locked sequence completes a full revolution.
REQ-014 err_cnt  output  CNT_W  saturating count of err pulses.

Function
REQ-015 Legal sample SHALL mean exactly one bit of rc_in set; 0000 and any multi-bit value are illegal.
REQ-016 Block SHALL hold prev_q (last sampled rc_in); expected = rotate(prev_q, DIR).
REQ-017 All outputs SHALL be registered; they reflect the rc_in sampled at the same rising edge (visible one cycle after rc_in is presented).
REQ-018 FSM states SHALL be UNSYNC, ACQUIRE, LOCKED; match_cnt is a 4-bit counter.
REQ-019 UNSYNC: legal sample -> ACQUIRE with match_cnt=1; illegal -> stay UNSYNC.
REQ-020 ACQUIRE: legal and equal to expected -> match_cnt+1; on reaching LOCK_CNT -> LOCKED.
REQ-021 ACQUIRE: legal but not expected -> stay ACQUIRE, match_cnt=1; illegal -> UNSYNC, match_cnt=0.
REQ-022 LOCKED: sample equal to expected -> stay, valid=1, idx updated.
REQ-023 LOCKED: legal mismatch -> err=1, valid=0, ACQUIRE with match_cnt=1; illegal -> err=1, valid=0, UNSYNC.
REQ-024 err SHALL never assert outside LOCKED; mismatches in UNSYNC/ACQUIRE are silent.
REQ-025 wrap SHALL pulse in LOCKED on a correct sample where idx goes 3->0 (DIR=0) or 0->3 (DIR=1).
REQ-026 idx SHALL update on every legal sample in any state; illegal samples leave idx unchanged.
REQ-027 prev_q SHALL load rc_in on every en=1 edge, legal or not.
REQ-028 en=0: all state, prev_q, idx, locked, err_cnt held; err, wrap, valid forced 0 that cycle.
REQ-029 err_cnt SHALL increment on err and saturate at 2^CNT_W-1.
REQ-030 clr_err and err on same edge: err_cnt SHALL become 1; clr_err alone -> 0.
REQ-031 clr_err SHALL act regardless of en.

Reset
REQ-032 reset=0 SHALL immediately force state UNSYNC, match_cnt=0, prev_q=0000, idx=0, valid=0, locked=0, err=0, wrap=0, err_cnt=0.
REQ-033 Reset mid-lock SHALL discard lock; after release, a full LOCK_CNT acquisition is required.
REQ-034 Release of reset SHALL take effect at the first rising edge with reset=1.

Verification
REQ-035 Reset: assert reset=0 mid-cycle with locked=1 -> all outputs 0 without a clock edge.
REQ-036 Lock, DIR=0, LOCK_CNT=4: en=1, rc_in 0010,0100,1000,0001 -> locked=1 after 4th edge; next 0010 -> valid=1, idx=1; 0001 sample gives wrap=1.
REQ-037 Fault: locked, expected 0100, drive 0110 -> err=1 one cycle, err_cnt=1, UNSYNC, locked=0; drive 1000 -> ACQUIRE, err=0.
REQ-038 Legal skip: locked at 0010, drive 1000 -> err=1, state ACQUIRE, match_cnt=1, idx=3.
REQ-039 Enable/clear: en=0 with rc_in=1111 for 5 cycles -> no state change, err=0; clr_err with simultaneous err -> err_cnt=1.
REQ-040 Saturation: CNT_W=2, force 5 faults -> err_cnt stays 3.

Source files
------------

// File: rtl/iiitb_rc_chk.sv
// Checks a 4-bit one-hot ring counter for legality and rotation direction, locks after
// LOCK_CNT consecutive correct rotations, and flags/counts faults seen while locked.
module iiitb_rc_chk #(
  parameter int LOCK_CNT = 4,
  parameter int DIR      = 0,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr_err,
  input  logic [3:0]       rc_in,
  output logic [1:0]       idx,
  output logic             valid,
  output logic             locked,
  output logic             err,
  output logic             wrap,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {UNSYNC, ACQUIRE, LOCKED} state_t;

  localparam logic [3:0]       LOCK_C   = 4'(LOCK_CNT);
  localparam logic [3:0]       WRAP_PAT = (DIR == 0) ? 4'b0001 : 4'b1000;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state, state_nxt;
  logic [3:0] match_cnt, match_nxt;
  logic [3:0] prev_q;
  logic [3:0] expected;
  logic       legal, hit;
  logic [1:0] enc;
  logic       err_nxt, valid_nxt, wrap_nxt;

  assign legal    = $onehot(rc_in);
  assign expected = (DIR == 0) ? {prev_q[2:0], prev_q[3]} : {prev_q[0], prev_q[3:1]};
  // prev_q of 0000 or multi-hot rotates to a non-one-hot value, so it can never hit
  assign hit      = legal && (rc_in == expected);

  always_comb begin
    enc = 2'd0;
    case (rc_in)
      4'b0010: enc = 2'd1;
      4'b0100: enc = 2'd2;
      4'b1000: enc = 2'd3;
      default: enc = 2'd0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    match_nxt = match_cnt;
    err_nxt   = 1'b0;
    valid_nxt = 1'b0;
    wrap_nxt  = 1'b0;
    if (en) begin
      case (state)
        UNSYNC: begin
          if (legal) begin
            state_nxt = ACQUIRE;
            match_nxt = 4'd1;
          end
        end
        ACQUIRE: begin
          if (!legal) begin
            state_nxt = UNSYNC;
            match_nxt = 4'd0;
          end else if (hit) begin
            match_nxt = match_cnt + 4'd1;
            if (match_nxt == LOCK_C) state_nxt = LOCKED;
          end else begin
            match_nxt = 4'd1;
          end
        end
        LOCKED: begin
          if (hit) begin
            valid_nxt = 1'b1;
            wrap_nxt  = (rc_in == WRAP_PAT);
          end else begin
            err_nxt = 1'b1;
            if (legal) begin
              state_nxt = ACQUIRE;
              match_nxt = 4'd1;
            end else begin
              state_nxt = UNSYNC;
              match_nxt = 4'd0;
            end
          end
        end
        default: begin
          state_nxt = UNSYNC;
          match_nxt = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= UNSYNC;
      match_cnt <= 4'd0;
      prev_q    <= 4'd0;
      idx       <= 2'd0;
      valid     <= 1'b0;
      locked    <= 1'b0;
      err       <= 1'b0;
      wrap      <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      match_cnt <= match_nxt;
      locked    <= (state_nxt == LOCKED);
      err       <= err_nxt;
      valid     <= valid_nxt;
      wrap      <= wrap_nxt;
      if (en) begin
        prev_q <= rc_in;
        if (legal) idx <= enc;
      end
      // a clear coinciding with a new fault keeps that fault counted
      if (clr_err)
        err_cnt <= err_nxt ? CNT_ONE : '0;
      else if (err_nxt && err_cnt != CNT_MAX)
        err_cnt <= err_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_iiitb_rc_chk.sv
// Bench for iiitb_rc_chk: a left-rotating instance (CNT_W=2) and a right-rotating instance
// fed the bit-reversed stream, checked every cycle against a sequence-level model.
module tb_iiitb_rc_chk;

  localparam int LOCK = 4;

  logic       clk = 1'b0;
  logic       reset, en, clr_err;
  logic [3:0] rc_in, rc_rev;
  logic [1:0] idx0, idx1;
  logic       valid0, valid1, locked0, locked1, err0, err1, wrap0, wrap1;
  logic [1:0] cnt0;
  logic [7:0] cnt1;

  int checks = 0;
  int failures = 0;

  assign rc_rev = {rc_in[0], rc_in[1], rc_in[2], rc_in[3]};

  iiitb_rc_chk #(.LOCK_CNT(LOCK), .DIR(0), .CNT_W(2)) u0 (
    .clk(clk), .reset(reset), .en(en), .clr_err(clr_err), .rc_in(rc_in),
    .idx(idx0), .valid(valid0), .locked(locked0), .err(err0), .wrap(wrap0), .err_cnt(cnt0));

  iiitb_rc_chk #(.LOCK_CNT(LOCK), .DIR(1), .CNT_W(8)) u1 (
    .clk(clk), .reset(reset), .en(en), .clr_err(clr_err), .rc_in(rc_rev),
    .idx(idx1), .valid(valid1), .locked(locked1), .err(err1), .wrap(wrap1), .err_cnt(cnt1));

  always #5 clk = ~clk;

  // Model: mode 0 = out of sync, 1 = acquiring, 2 = locked; run = consecutive good samples.
  int m_mode[2], m_run[2], m_prev_pos[2], m_idx[2], m_cnt[2];
  bit m_prev_legal[2], m_valid[2], m_err[2], m_wrap[2];

  function automatic int pos_of(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        m_mode[k] = 0; m_run[k] = 0; m_prev_pos[k] = 0; m_prev_legal[k] = 0;
        m_idx[k] = 0; m_cnt[k] = 0; m_valid[k] = 0; m_err[k] = 0; m_wrap[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        logic [3:0] r;
        bit lg, ok;
        int p, max;
        r   = (k == 0) ? rc_in : rc_rev;
        max = (k == 0) ? 3 : 255;
        lg  = ($countones(r) == 1);
        p   = pos_of(r);
        ok  = lg && m_prev_legal[k] && (p == (m_prev_pos[k] + ((k == 0) ? 1 : 3)) % 4);
        m_valid[k] = 0; m_err[k] = 0; m_wrap[k] = 0;
        if (en) begin
          if (m_mode[k] == 0) begin
            if (lg) begin m_mode[k] = 1; m_run[k] = 1; end
          end else if (m_mode[k] == 1) begin
            if (!lg) begin m_mode[k] = 0; m_run[k] = 0; end
            else if (ok) begin m_run[k]++; if (m_run[k] == LOCK) m_mode[k] = 2; end
            else m_run[k] = 1;
          end else begin
            if (ok) begin
              m_valid[k] = 1;
              m_wrap[k]  = (p == ((k == 0) ? 0 : 3));
            end else begin
              m_err[k] = 1;
              if (lg) begin m_mode[k] = 1; m_run[k] = 1; end
              else begin m_mode[k] = 0; m_run[k] = 0; end
            end
          end
          if (lg) m_idx[k] = p;
          m_prev_legal[k] = lg;
          m_prev_pos[k]   = p;
        end
        if (clr_err) m_cnt[k] = m_err[k] ? 1 : 0;
        else if (m_err[k] && m_cnt[k] < max) m_cnt[k]++;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("u0_idx", int'(idx0), m_idx[0]);
    chk("u0_valid", int'(valid0), int'(m_valid[0]));
    chk("u0_locked", int'(locked0), int'(m_mode[0] == 2));
    chk("u0_err", int'(err0), int'(m_err[0]));
    chk("u0_wrap", int'(wrap0), int'(m_wrap[0]));
    chk("u0_err_cnt", int'(cnt0), m_cnt[0]);
    chk("u1_idx", int'(idx1), m_idx[1]);
    chk("u1_valid", int'(valid1), int'(m_valid[1]));
    chk("u1_locked", int'(locked1), int'(m_mode[1] == 2));
    chk("u1_err", int'(err1), int'(m_err[1]));
    chk("u1_wrap", int'(wrap1), int'(m_wrap[1]));
    chk("u1_err_cnt", int'(cnt1), m_cnt[1]);
  end

  task automatic step(input logic e, input logic c, input logic [3:0] r);
    en = e; clr_err = c; rc_in = r;
    @(posedge clk);
    #1;
  endtask

  task automatic lock_seq(input logic [3:0] a, b, c, d);
    step(1'b1, 1'b0, a); step(1'b1, 1'b0, b); step(1'b1, 1'b0, c); step(1'b1, 1'b0, d);
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; clr_err = 1'b0; rc_in = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked", int'(locked0), 0);
    chk("rst_err_cnt", int'(cnt0), 0);
    reset = 1'b1;

    step(1'b1, 1'b0, 4'b0010);
    chk("acq_idx0", int'(idx0), 1);
    chk("acq_idx1", int'(idx1), 2);
    step(1'b1, 1'b0, 4'b0100);
    step(1'b1, 1'b0, 4'b1000);
    chk("pre_lock", int'(locked0), 0);
    step(1'b1, 1'b0, 4'b0001);
    chk("lock0", int'(locked0), 1);
    chk("lock1", int'(locked1), 1);
    chk("lock_idx", int'(idx0), 0);
    step(1'b1, 1'b0, 4'b0010);
    chk("valid0", int'(valid0), 1);
    chk("valid_idx", int'(idx0), 1);
    chk("valid1", int'(valid1), 1);
    step(1'b1, 1'b0, 4'b0100);
    step(1'b1, 1'b0, 4'b1000);
    chk("no_wrap", int'(wrap0), 0);
    step(1'b1, 1'b0, 4'b0001);
    chk("wrap0", int'(wrap0), 1);
    chk("wrap1", int'(wrap1), 1);
    step(1'b1, 1'b0, 4'b0010);

    // multi-hot fault while locked
    step(1'b1, 1'b0, 4'b0110);
    chk("fault_err", int'(err0), 1);
    chk("fault_locked", int'(locked0), 0);
    chk("fault_cnt", int'(cnt0), 1);
    chk("fault_idx_held", int'(idx0), 1);
    step(1'b1, 1'b0, 4'b1000);
    chk("fault_err_gone", int'(err0), 0);
    chk("fault_reacq_idx", int'(idx0), 3);
    lock_seq(4'b0001, 4'b0010, 4'b0100, 4'b1000);
    step(1'b1, 1'b0, 4'b0001);
    step(1'b1, 1'b0, 4'b0010);
    chk("relocked_valid", int'(valid0), 1);

    // legal skip 0010 -> 1000: acquisition restarts at count 1
    step(1'b1, 1'b0, 4'b1000);
    chk("skip_err", int'(err0), 1);
    chk("skip_idx", int'(idx0), 3);
    chk("skip_cnt", int'(cnt0), 2);
    step(1'b1, 1'b0, 4'b0001);
    step(1'b1, 1'b0, 4'b0010);
    chk("skip_not_yet", int'(locked0), 0);
    step(1'b1, 1'b0, 4'b0100);
    chk("skip_relock", int'(locked0), 1);

    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 4'b1111);
      chk("en0_err", int'(err0), 0);
      chk("en0_locked", int'(locked0), 1);
      chk("en0_idx", int'(idx0), 2);
    end
    step(1'b1, 1'b0, 4'b1000);
    chk("en0_prev_held", int'(valid0), 1);

    step(1'b1, 1'b1, 4'b0000);
    chk("clr_with_err", int'(err0), 1);
    chk("clr_with_err_cnt0", int'(cnt0), 1);
    chk("clr_with_err_cnt1", int'(cnt1), 1);
    step(1'b0, 1'b1, 4'b0000);
    chk("clr_alone", int'(cnt0), 0);

    for (int i = 0; i < 5; i++) begin
      lock_seq(4'b0001, 4'b0010, 4'b0100, 4'b1000);
      step(1'b1, 1'b0, 4'b1111);
    end
    chk("sat_cnt0", int'(cnt0), 3);
    chk("sat_cnt1", int'(cnt1), 5);

    lock_seq(4'b0001, 4'b0010, 4'b0100, 4'b1000);
    chk("pre_rst_locked", int'(locked0), 1);
    reset = 1'b0;
    #1;
    chk("async_locked", int'(locked0), 0);
    chk("async_idx", int'(idx0), 0);
    chk("async_cnt", int'(cnt0), 0);
    chk("async_valid", int'(valid0), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(1'b1, 1'b0, 4'b0010);
    step(1'b1, 1'b0, 4'b0100);
    step(1'b1, 1'b0, 4'b1000);
    chk("post_rst_unlocked", int'(locked0), 0);
    step(1'b1, 1'b0, 4'b0001);
    chk("post_rst_locked", int'(locked0), 1);

    step(1'b0, 1'b0, 4'b0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
